// File: rtl/ffs_slot_pool.sv
// Free-slot allocator: MSB-first find-first-set offers the next free slot, the free side re-sets a decoded slot bit.
// Optional FFS_SLOT_POOL_DOUBLE_FREE_CHK_EN adds a sticky double-free flag plus a simulation assertion.
module ffs_slot_pool #(
  parameter int N_CANDIDATES = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  output logic                            o_alloc_valid,
  input  logic                            i_alloc_ready,
  output logic [$clog2(N_CANDIDATES)-1:0] o_alloc_index,
  input  logic                            i_free_valid,
  output logic                            o_free_ready,
  input  logic [$clog2(N_CANDIDATES)-1:0] i_free_index,
  output logic [N_CANDIDATES-1:0]         o_free_map,
  output logic [$clog2(N_CANDIDATES):0]   o_count,
  output logic                            o_empty,
  output logic                            o_full,
  output logic                            o_err_double_free
);
  localparam int IW = $clog2(N_CANDIDATES);

  logic [N_CANDIDATES-1:0] free_map, map_next, alloc_mask, free_mask;
  logic [IW:0]             count, count_next;
  logic [IW-1:0]           alloc_index;
  logic                    alloc_fire, free_fire, double_free, valid_free;

  // Slot k lives at bit N-1-k; scanning k downward leaves the lowest free k.
  always_comb begin
    alloc_index = '0;
    for (int k = N_CANDIDATES - 1; k >= 0; k--)
      if (free_map[N_CANDIDATES-1-k]) alloc_index = IW'(k);
  end

  for (genvar g = 0; g < N_CANDIDATES; g++) begin : g_dec
    assign alloc_mask[g] = (alloc_index  == IW'(N_CANDIDATES - 1 - g));
    assign free_mask[g]  = (i_free_index == IW'(N_CANDIDATES - 1 - g));
  end

  assign alloc_fire  = o_alloc_valid && i_alloc_ready;
  assign free_fire   = i_free_valid;
  assign double_free = free_fire && |(free_map & free_mask);
  assign valid_free  = free_fire && !double_free;

  // Clear is applied after set so a same-slot alloc/free ends allocated.
  always_comb begin
    map_next = free_map;
    if (valid_free) map_next = map_next | free_mask;
    if (alloc_fire) map_next = map_next & ~alloc_mask;
    count_next = count - (IW+1)'(alloc_fire) + (IW+1)'(valid_free);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      free_map <= '1;
      count    <= (IW+1)'(N_CANDIDATES);
    end else begin
      free_map <= map_next;
      count    <= count_next;
    end
  end

  assign o_alloc_valid = |free_map;
  assign o_alloc_index = alloc_index;
  assign o_free_ready  = 1'b1;
  assign o_free_map    = free_map;
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_full        = (count == (IW+1)'(N_CANDIDATES));

`ifdef FFS_SLOT_POOL_DOUBLE_FREE_CHK_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) err_q <= 1'b0;
    else if (double_free) err_q <= 1'b1;
  end
  assign o_err_double_free = err_q;

`ifndef SYNTHESIS
  a_no_double_free: assert property (@(posedge i_clk) disable iff (i_reset) !double_free)
    else $error("double free of slot %0d", i_free_index);
`endif
`else
  assign o_err_double_free = 1'b0;
`endif
endmodule

// File: tb/tb_ffs_slot_pool.sv
// Directed bench for ffs_slot_pool (N_CANDIDATES = 8): drain, free, mixed alloc/free, double free, reset priority.
module tb_ffs_slot_pool;
  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid, alloc_ready;
  logic [2:0] alloc_index;
  logic       free_valid, free_ready;
  logic [2:0] free_index;
  logic [7:0] free_map;
  logic [3:0] count;
  logic       empty, full, err;
  int         vectors = 0;
  int         miscompares = 0;

`ifdef FFS_SLOT_POOL_DOUBLE_FREE_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  ffs_slot_pool #(.N_CANDIDATES(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .o_alloc_valid(alloc_valid), .i_alloc_ready(alloc_ready), .o_alloc_index(alloc_index),
    .i_free_valid(free_valid), .o_free_ready(free_ready), .i_free_index(free_index),
    .o_free_map(free_map), .o_count(count), .o_empty(empty), .o_full(full),
    .o_err_double_free(err)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic free_one(input logic [2:0] idx);
    free_valid = 1'b1; free_index = idx;
    step();
    free_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    vectors++; if (free_map !== 8'hFF) begin miscompares++; $display("FAIL reset_map got %h want ff", free_map); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL reset_count got %0d want 8", count); end
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL reset_flags got full=%b empty=%b want 1/0", full, empty); end
    vectors++; if (alloc_valid !== 1'b1 || alloc_index !== 3'd0) begin miscompares++; $display("FAIL reset_offer got v=%b idx=%0d want 1/0", alloc_valid, alloc_index); end
    vectors++; if (err !== 1'b0 || free_ready !== 1'b1) begin miscompares++; $display("FAIL reset_err_ready got err=%b rdy=%b want 0/1", err, free_ready); end
    step();
    vectors++; if (alloc_index !== 3'd0 || free_map !== 8'hFF) begin miscompares++; $display("FAIL idle_hold got idx=%0d map=%h want 0/ff", alloc_index, free_map); end
  endtask

  task automatic test_drain();
    alloc_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (alloc_valid !== 1'b1 || alloc_index !== 3'(k)) begin miscompares++; $display("FAIL drain_idx%0d got v=%b idx=%0d want 1/%0d", k, alloc_valid, alloc_index, k); end
      step();
    end
    vectors++; if (alloc_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL drain_flags got v=%b e=%b f=%b want 0/1/0", alloc_valid, empty, full); end
    vectors++; if (count !== 4'd0 || free_map !== 8'h00 || alloc_index !== 3'd0) begin miscompares++; $display("FAIL drain_state got cnt=%0d map=%h idx=%0d want 0/00/0", count, free_map, alloc_index); end
    step();
    vectors++; if (count !== 4'd0 || free_map !== 8'h00) begin miscompares++; $display("FAIL ready_when_empty got cnt=%0d map=%h want 0/00", count, free_map); end
    alloc_ready = 1'b0;
  endtask

  task automatic test_free_from_empty();
    free_valid = 1'b1; free_index = 3'd5;
    vectors++; if (alloc_valid !== 1'b0) begin miscompares++; $display("FAIL no_bypass got v=%b want 0", alloc_valid); end
    step(); free_valid = 1'b0;
    vectors++; if (free_map !== 8'h04 || count !== 4'd1) begin miscompares++; $display("FAIL free5 got map=%h cnt=%0d want 04/1", free_map, count); end
    vectors++; if (alloc_index !== 3'd5 || alloc_valid !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL free5_offer got idx=%0d v=%b e=%b want 5/1/0", alloc_index, alloc_valid, empty); end
  endtask

  task automatic test_alloc_free_same_cycle();
    free_one(3'd4); free_one(3'd6); free_one(3'd7);
    vectors++; if (free_map !== 8'h0F || count !== 4'd4) begin miscompares++; $display("FAIL setup_0f got map=%h cnt=%0d want 0f/4", free_map, count); end
    alloc_ready = 1'b1; free_valid = 1'b1; free_index = 3'd1;
    vectors++; if (alloc_index !== 3'd4) begin miscompares++; $display("FAIL mix_offer got idx=%0d want 4", alloc_index); end
    step(); alloc_ready = 1'b0; free_valid = 1'b0;
    vectors++; if (free_map !== 8'h47 || count !== 4'd4) begin miscompares++; $display("FAIL mix got map=%h cnt=%0d want 47/4", free_map, count); end
    vectors++; if (alloc_index !== 3'd1) begin miscompares++; $display("FAIL mix_next got idx=%0d want 1", alloc_index); end
  endtask

  task automatic test_double_free();
    alloc_ready = 1'b1; step(); alloc_ready = 1'b0;
    free_one(3'd4);
    vectors++; if (free_map !== 8'h0F || count !== 4'd4 || err !== 1'b0) begin miscompares++; $display("FAIL setup2 got map=%h cnt=%0d err=%b want 0f/4/0", free_map, count, err); end
    free_one(3'd6);
    vectors++; if (free_map !== 8'h0F || count !== 4'd4) begin miscompares++; $display("FAIL dfree_ignored got map=%h cnt=%0d want 0f/4", free_map, count); end
    vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL dfree_err got %b want %b", err, ERR_EXP); end
    step();
    vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL dfree_sticky got %b want %b", err, ERR_EXP); end
    alloc_ready = 1'b1; free_valid = 1'b1; free_index = 3'd4;
    vectors++; if (alloc_index !== 3'd4) begin miscompares++; $display("FAIL same_offer got idx=%0d want 4", alloc_index); end
    step(); alloc_ready = 1'b0; free_valid = 1'b0;
    vectors++; if (free_map !== 8'h07 || count !== 4'd3) begin miscompares++; $display("FAIL same_idx got map=%h cnt=%0d want 07/3", free_map, count); end
    vectors++; if (alloc_index !== 3'd5 || err !== ERR_EXP) begin miscompares++; $display("FAIL same_idx_next got idx=%0d err=%b want 5/%b", alloc_index, err, ERR_EXP); end
  endtask

  task automatic test_reset_priority();
    alloc_ready = 1'b1; step(); step(); step(); alloc_ready = 1'b0;
    vectors++; if (free_map !== 8'h00 || count !== 4'd0) begin miscompares++; $display("FAIL setup_empty got map=%h cnt=%0d want 00/0", free_map, count); end
    rst = 1'b1; free_valid = 1'b1; free_index = 3'd2; alloc_ready = 1'b1;
    step(); rst = 1'b0; free_valid = 1'b0; alloc_ready = 1'b0;
    vectors++; if (free_map !== 8'hFF || count !== 4'd8 || full !== 1'b1) begin miscompares++; $display("FAIL rst_prio got map=%h cnt=%0d full=%b want ff/8/1", free_map, count, full); end
    vectors++; if (err !== 1'b0 || alloc_index !== 3'd0) begin miscompares++; $display("FAIL rst_prio_err got err=%b idx=%0d want 0/0", err, alloc_index); end
  endtask

  initial begin
    rst = 1'b1; alloc_ready = 1'b0; free_valid = 1'b0; free_index = '0;
    test_reset();
    test_drain();
    test_free_from_empty();
    test_alloc_free_same_cycle();
    test_double_free();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
